// File: rtl/homomorphic_frame_ctrl.sv
// Frame sequencer for the homomorphic filter chain: streams |x| from the sample RAM to the
// log stage, then collects the decimated results, removes the DC offset and writes them out.
module homomorphic_frame_ctrl #(
    parameter int unsigned   DW      = 32,
    parameter int unsigned   AW      = 13,
    parameter int unsigned   DECIM   = 4,
    parameter logic [DW-1:0] OFFSET  = 32'h0400_0000,
    parameter int unsigned   TIMEOUT = 1024
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          start,
    input  logic [AW:0]   frame_len,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [1:0]    err,
    output logic [AW-1:0] rd_addr,
    output logic          rd_en,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    input  logic [DW-1:0] s_res_tdata,
    input  logic          s_res_tvalid,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] len_q, len_d, exp_q, exp_d;
    logic [LW-1:0] rd_cnt_q, rd_cnt_d, sent_q, sent_d, res_cnt_q, res_cnt_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [DW-1:0] fifo_q [2];
    logic [DW-1:0] fifo_d [2];
    logic          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          inflight_q, inflight_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    err_q, err_d;
    logic          done_q, done_d;
    logic          wr_en_q, wr_en_d;
    logic [DW-1:0] wr_data_q, wr_data_d;

    logic          is_busy, start_ok, abort_ok, pop, push, last_beat;
    logic          res_acc, all_res, tmo_hit, rd_go;
    logic [2:0]    occ;
    logic [DW-1:0] abs_x;

    assign is_busy   = (state_q == StFetch) || (state_q == StDrain);
    assign start_ok  = start && !is_busy;
    assign abort_ok  = abort && is_busy;
    assign pop       = (cnt_q != 2'd0) && m_axis_tready;
    assign push      = inflight_q && (state_q == StFetch) && !abort_ok;
    assign last_beat = pop && (sent_q == len_q - LW'(1));
    assign res_acc   = s_res_tvalid && is_busy && (res_cnt_q < exp_q);
    assign all_res   = (res_cnt_q == exp_q);
    assign tmo_hit   = !s_res_tvalid && (tmo_q == TW'(TIMEOUT - 1));
    // Occupancy after this cycle's pop, so a steady tready keeps one beat per cycle.
    assign occ       = {1'b0, cnt_q} - {2'b0, pop} + {2'b0, inflight_q};
    assign rd_go     = (state_q == StFetch) && !abort && (occ < 3'd2) && (rd_cnt_q < len_q);

    always_comb begin
        if (rd_data == {1'b1, {(DW-1){1'b0}}}) begin
            abs_x = {1'b0, {(DW-1){1'b1}}};
        end else if (rd_data[DW-1]) begin
            abs_x = '0 - rd_data;
        end else begin
            abs_x = rd_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_ok) state_d = (frame_len == '0) ? StDone : StFetch;
            end
            StFetch: begin
                if (abort_ok)       state_d = StDone;
                else if (last_beat) state_d = StDrain;
            end
            StDrain: begin
                if (abort_ok || all_res || tmo_hit) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy          = is_busy;
        rd_en         = rd_go;
        rd_addr       = rd_addr_q;
        m_axis_tvalid = (cnt_q != 2'd0);
        m_axis_tdata  = fifo_q[rptr_q];
        done          = done_q;
        err           = err_q;
        wr_en         = wr_en_q;
        wr_addr       = wr_addr_q;
        wr_data       = wr_data_q;
    end

    always_comb begin
        len_d      = len_q;
        exp_d      = exp_q;
        rd_cnt_d   = rd_cnt_q;
        sent_d     = sent_q;
        res_cnt_d  = res_cnt_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        fifo_d     = fifo_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
        inflight_d = rd_go;
        err_d      = err_q;
        wr_en_d    = res_acc;
        wr_data_d  = res_acc ? (s_res_tdata - OFFSET) : wr_data_q;
        tmo_d      = ((state_q == StDrain) && !s_res_tvalid) ? tmo_q + TW'(1) : '0;
        done_d     = (state_d == StDone) && ((state_q != StDone) || start_ok);
        if (start_ok) begin
            len_d      = frame_len;
            exp_d      = LW'(32'(frame_len) / DECIM);
            rd_cnt_d   = '0;
            sent_d     = '0;
            res_cnt_d  = '0;
            rd_addr_d  = '0;
            wr_addr_d  = '0;
            wptr_d     = 1'b0;
            rptr_d     = 1'b0;
            cnt_d      = '0;
            inflight_d = 1'b0;
            err_d      = 2'd0;
        end else begin
            if (rd_go) begin
                rd_addr_d = rd_addr_q + AW'(1);
                rd_cnt_d  = rd_cnt_q + LW'(1);
            end
            if (push) begin
                fifo_d[wptr_q] = abs_x;
                wptr_d         = ~wptr_q;
            end
            if (pop) begin
                rptr_d = ~rptr_q;
                sent_d = sent_q + LW'(1);
            end
            if (res_acc) res_cnt_d = res_cnt_q + LW'(1);
            if (wr_en_q) wr_addr_d = wr_addr_q + AW'(1);
            if (abort_ok) begin
                cnt_d      = '0;
                inflight_d = 1'b0;
                err_d      = 2'd2;
            end else if ((state_q == StDrain) && !all_res && tmo_hit) begin
                err_d = 2'd1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            len_q      <= '0;
            exp_q      <= '0;
            rd_cnt_q   <= '0;
            sent_q     <= '0;
            res_cnt_q  <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            tmo_q      <= '0;
            err_q      <= 2'd0;
            done_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            len_q      <= len_d;
            exp_q      <= exp_d;
            rd_cnt_q   <= rd_cnt_d;
            sent_q     <= sent_d;
            res_cnt_q  <= res_cnt_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            fifo_q     <= fifo_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            done_q     <= done_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_homomorphic_frame_ctrl.sv
// Scoreboard bench for homomorphic_frame_ctrl: randomized frames, a queue-based reference model
// and a negedge monitor that checks AXIS beats, output RAM writes and handshake stability.
module tb_homomorphic_frame_ctrl;

    localparam int          DW      = 32;
    localparam int          AW      = 13;
    localparam int          DECIM   = 4;
    localparam int          TIMEOUT = 1024;
    localparam logic [31:0] OFFSET  = 32'h0400_0000;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   frame_len = '0;
    logic          abort = 1'b0;
    logic          busy, done, rd_en, m_axis_tvalid, wr_en;
    logic [1:0]    err;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] m_axis_tdata, wr_data;
    logic          m_axis_tready = 1'b1;
    logic [DW-1:0] s_res_tdata = '0;
    logic          s_res_tvalid = 1'b0;

    homomorphic_frame_ctrl dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (start),
        .frame_len     (frame_len),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .rd_addr       (rd_addr),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .s_res_tdata   (s_res_tdata),
        .s_res_tvalid  (s_res_tvalid),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data)
    );

    always #5 aclk = ~aclk;

    // Sample RAM with one cycle read latency.
    logic [DW-1:0] ram [1 << AW];
    always @(posedge aclk) if (rd_en) rd_data <= ram[rd_addr];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic [DW-1:0] exp_beats[$];
    wr_t           exp_wr[$];
    int            n_cmp = 0, n_bad = 0;
    int            cyc = 0;
    int            done_cnt = 0, rd_en_cnt = 0, wr_cnt = 0, beat_cnt = 0;
    int            first_beat_cyc = 0, last_beat_cyc = 0, last_wr_cyc = 0;
    logic [DW-1:0] first_beat_data = '0;
    bit            rnd_ready = 1'b0;
    int            model_exp = 0, model_res = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Magnitude with saturation of the most negative value.
    function automatic logic [DW-1:0] mag(input logic [DW-1:0] s);
        longint v;
        v = longint'($signed(s));
        if (v < 0) v = -v;
        if (v > 64'sd2147483647) v = 64'sd2147483647;
        return v[DW-1:0];
    endfunction

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    initial forever begin
        @(posedge aclk);
        #1;
        m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: samples mid-cycle, when all handshake signals are settled.
    initial begin
        bit            prev_stall;
        bit            prev_abort;
        logic [DW-1:0] prev_data;
        wr_t           e;
        prev_stall = 1'b0;
        prev_abort = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                if (prev_stall && !prev_abort)
                    chk("axis_stable", {m_axis_tvalid, m_axis_tdata}, {1'b1, prev_data});
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_beats.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL beat_extra: got %0h, expected no beat", m_axis_tdata);
                    end else begin
                        chk("beat", m_axis_tdata, exp_beats.pop_front());
                    end
                    if (beat_cnt == 0) begin
                        first_beat_cyc  = cyc;
                        first_beat_data = m_axis_tdata;
                    end
                    last_beat_cyc = cyc;
                    beat_cnt++;
                end
                if (wr_en) begin
                    if (exp_wr.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL wr_extra: got addr %0h data %0h, expected no write",
                                 wr_addr, wr_data);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("wr_addr_data", {wr_addr, wr_data}, {e.addr, e.data});
                    end
                    wr_cnt++;
                    last_wr_cyc = cyc;
                end
                if (rd_en) rd_en_cnt++;
                if (done) done_cnt++;
            end
            prev_stall = aresetn && m_axis_tvalid && !m_axis_tready;
            prev_abort = abort;
            prev_data  = m_axis_tdata;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic start_frame(input int len);
        model_exp = len / DECIM;
        model_res = 0;
        for (int i = 0; i < len; i++) exp_beats.push_back(mag(ram[i]));
        frame_len = (AW+1)'(len);
        start     = 1'b1;
        step(1);
        start     = 1'b0;
    endtask

    task automatic send_res(input int n, input int gapmax);
        logic [DW-1:0] d;
        wr_t           w;
        for (int i = 0; i < n; i++) begin
            d            = $urandom;
            s_res_tdata  = d;
            s_res_tvalid = 1'b1;
            if (model_res < model_exp) begin
                w.addr = AW'(model_res);
                w.data = d - OFFSET;
                exp_wr.push_back(w);
            end
            model_res++;
            step(1);
            s_res_tvalid = 1'b0;
            step($urandom_range(0, gapmax));
        end
    endtask

    task automatic wait_done(input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge aclk);
            if (done) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_wait: no done within %0d cycles, expected a done pulse", bound);
        end
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < 8; i++)
            ram[i] = (i % 2 == 1) ? DW'(2 * i + 3) : DW'(-(2 * i + 3));
    endtask

    initial begin
        int at, ab, d0, w0, r0;

        // Reset state
        #12;
        chk("rst_ctrl", {busy, done, rd_en, m_axis_tvalid, wr_en}, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", {rd_addr, wr_addr}, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        step(2);

        // 1: short frame, tready held high
        fill_pattern();
        d0 = done_cnt; w0 = wr_cnt; beat_cnt = 0;
        start_frame(8);
        send_res(2, 1);
        wait_done(100, at);
        step(3);
        chk("t1_err", err, 0);
        chk("t1_beats", beat_cnt, 8);
        chk("t1_back_to_back", last_beat_cyc - first_beat_cyc, 7);
        chk("t1_writes", wr_cnt - w0, 2);
        chk("t1_done_pulse", done_cnt - d0, 1);
        chk("t1_idle", {busy, m_axis_tvalid}, 0);
        chk("t1_queues", exp_beats.size() + exp_wr.size(), 0);

        // 2: long random frame with random backpressure and surplus results
        for (int i = 0; i < 5120; i++) ram[i] = (i % 97 == 5) ? 32'h8000_0000 : $urandom;
        rnd_ready = 1'b1;
        d0 = done_cnt; w0 = wr_cnt; beat_cnt = 0;
        start_frame(5120);
        send_res(1282, 3);
        wait_done(30000, at);
        rnd_ready = 1'b0;
        step(3);
        chk("t2_err", err, 0);
        chk("t2_beats", beat_cnt, 5120);
        chk("t2_writes", wr_cnt - w0, 1280);
        chk("t2_done_pulse", done_cnt - d0, 1);
        chk("t2_queues", exp_beats.size() + exp_wr.size(), 0);

        // 3: saturation of the most negative sample
        ram[0] = 32'h8000_0000; ram[1] = 32'h7FFF_FFFF; ram[2] = 32'h0; ram[3] = 32'hFFFF_FFFF;
        beat_cnt = 0;
        start_frame(4);
        send_res(1, 0);
        wait_done(100, at);
        step(2);
        chk("t3_sat", first_beat_data, 32'h7FFF_FFFF);
        chk("t3_beats", beat_cnt, 4);
        chk("t3_queues", exp_beats.size() + exp_wr.size(), 0);

        // 4: empty frame, plus a result arriving while DONE
        d0 = done_cnt; w0 = wr_cnt; r0 = rd_en_cnt;
        start_frame(0);
        wait_done(2, at);
        send_res(1, 0);
        step(3);
        chk("t4_err", err, 0);
        chk("t4_done_pulse", done_cnt - d0, 1);
        chk("t4_no_reads", rd_en_cnt - r0, 0);
        chk("t4_no_writes", wr_cnt - w0, 0);

        // 5a: results stop during DRAIN -> timeout
        for (int i = 0; i < 8; i++) ram[i] = $urandom;
        w0 = wr_cnt;
        start_frame(8);
        step(20);
        send_res(1, 0);
        wait_done(TIMEOUT + 50, at);
        chk("t5_tmo_err", err, 1);
        chk("t5_tmo_cycles", at - last_wr_cyc, TIMEOUT);
        chk("t5_tmo_writes", wr_cnt - w0, 1);
        step(5);
        chk("t5_err_held", err, 1);
        chk("t5_queues", exp_beats.size() + exp_wr.size(), 0);

        // 5b: abort mid-FETCH
        for (int i = 0; i < 64; i++) ram[i] = $urandom;
        rnd_ready = 1'b1;
        start_frame(64);
        step(12);
        abort = 1'b1;
        ab = cyc;
        step(1);
        abort = 1'b0;
        wait_done(4, at);
        chk("t5_abort_latency", at - ab, 1);
        chk("t5_abort_err", err, 2);
        chk("t5_abort_tvalid", {busy, m_axis_tvalid}, 0);
        exp_beats.delete();
        rnd_ready = 1'b0;
        step(5);
        chk("t5_abort_wr_queue", exp_wr.size(), 0);

        // 6: asynchronous reset mid-FETCH, then a clean frame
        for (int i = 0; i < 32; i++) ram[i] = $urandom;
        rnd_ready = 1'b1;
        start_frame(32);
        step(8);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_rst_ctrl", {busy, done, rd_en, m_axis_tvalid, wr_en}, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_addr", {rd_addr, wr_addr}, 0);
        exp_beats.delete();
        @(negedge aclk);
        aresetn = 1'b1;
        rnd_ready = 1'b0;
        step(2);
        fill_pattern();
        d0 = done_cnt; w0 = wr_cnt; beat_cnt = 0;
        start_frame(8);
        send_res(2, 1);
        wait_done(100, at);
        step(3);
        chk("t6_err", err, 0);
        chk("t6_beats", beat_cnt, 8);
        chk("t6_writes", wr_cnt - w0, 2);
        chk("t6_done_pulse", done_cnt - d0, 1);
        chk("t6_queues", exp_beats.size() + exp_wr.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
